// File: rtl/ws2812_frame_sequencer.sv
// Streams a small frame buffer of 24-bit GRB words into the WS2812 bit controller,
// then holds the line idle for the latch gap and pulses frame_done.
module ws2812_frame_sequencer #(
  parameter int F_CLK    = 50_000_000,
  parameter int NUM_LEDS = 8,
  parameter int LATCH_US = 80,
  parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [23:0]       pix_data,
  output logic              pix_load,
  input  logic              pix_done
);

  localparam int LATCH_CYCLES = (F_CLK / 1_000_000) * LATCH_US;
  localparam int CNT_W        = $clog2(LATCH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   NUM_LEDS_EXT = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [CNT_W-1:0]  LATCH_LOAD   = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [23:0]       data_nxt;
  logic              load_nxt;
  logic              done_nxt;

  logic [23:0] mem [NUM_LEDS];

  // Frame buffer is deliberately left out of reset so a frame can be re-sent after a reset.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < NUM_LEDS_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign idx_inc = idx + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pix_data   <= '0;
      pix_load   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      pix_data   <= data_nxt;
      pix_load   <= load_nxt;
      frame_done <= done_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Pixel words are fetched on the edge into their load cycle, so late writes still land.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    data_nxt  = pix_data;
    load_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
          load_nxt  = 1'b1;
          data_nxt  = mem[0];
        end
      end
      LOAD: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (pix_done) begin
          if (idx == LAST_IDX) begin
            state_nxt = LATCH;
            cnt_nxt   = LATCH_LOAD;
          end else begin
            state_nxt = LOAD;
            idx_nxt   = idx_inc;
            load_nxt  = 1'b1;
            data_nxt  = mem[idx_inc];
          end
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer: emulates the bit controller handshake and
// checks every cycle against a transaction-level model plus literal frame expectations.
module tb_ws2812_frame_sequencer;

  localparam int N     = 8;
  localparam int LATCH = 4000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic        pix_done = 1'b0;
  logic        busy, frame_done, pix_load;
  logic [23:0] pix_data;

  // single-pixel instance with a short latch gap
  logic        s_wr_en = 1'b0;
  logic [0:0]  s_wr_addr = '0;
  logic [23:0] s_wr_data = '0;
  logic        s_start = 1'b0;
  logic        s_pix_done = 1'b0;
  logic        s_busy, s_frame_done, s_pix_load;
  logic [23:0] s_pix_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [23:0] got [N];

  always #5 clk = ~clk;

  ws2812_frame_sequencer #(
    .F_CLK(50_000_000), .NUM_LEDS(N), .LATCH_US(80)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .frame_done(frame_done), .pix_data(pix_data),
    .pix_load(pix_load), .pix_done(pix_done)
  );

  ws2812_frame_sequencer #(
    .F_CLK(1_000_000), .NUM_LEDS(1), .LATCH_US(50)
  ) dut_one (
    .clk(clk), .reset_n(reset_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .start(s_start), .busy(s_busy), .frame_done(s_frame_done), .pix_data(s_pix_data),
    .pix_load(s_pix_load), .pix_done(s_pix_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a frame is a sequence of pixel loads, each triggered by
  // start or by an accepted pix_done, followed by LATCH idle cycles and a done pulse.
  logic [23:0] m_mem [N];
  bit          m_active = 0;
  int          m_pix = 0;
  int          m_latch_left = 0;
  logic        exp_load = 0, exp_done = 0, exp_busy = 0;
  logic [23:0] exp_data = '0;

  always @(negedge clk) begin
    logic        nl, nd;
    logic [23:0] ndata;
    if (!reset_n) begin
      cmp("rst_busy", busy, 0);
      cmp("rst_frame_done", frame_done, 0);
      cmp("rst_pix_load", pix_load, 0);
      cmp("rst_pix_data", pix_data, 0);
      m_active = 0; m_latch_left = 0; m_pix = 0;
      exp_load = 0; exp_done = 0; exp_busy = 0; exp_data = '0;
    end else begin
      cmp("busy", busy, exp_busy);
      cmp("frame_done", frame_done, exp_done);
      cmp("pix_load", pix_load, exp_load);
      cmp("pix_data", pix_data, exp_data);
      nl = 0; nd = 0; ndata = exp_data;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_pix = 0; nl = 1; ndata = m_mem[0];
        end
      end else if (m_latch_left > 0) begin
        m_latch_left--;
        if (m_latch_left == 0) begin
          m_active = 0; nd = 1;
        end
      end else if (!exp_load && pix_done) begin
        if (m_pix == N - 1) m_latch_left = LATCH;
        else begin
          m_pix++; nl = 1; ndata = m_mem[m_pix];
        end
      end
      exp_load = nl; exp_done = nd; exp_data = ndata; exp_busy = m_active;
    end
    if (wr_en && int'(wr_addr) < N) m_mem[wr_addr] = wr_data;
  end

  task automatic wait_load(output bit seen);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (pix_load) begin
        seen = 1;
        return;
      end
      tick();
    end
  endtask

  // mode 0: plain; 1: stray start/pix_done; 2: live write of mem[5] during pixel 2
  task automatic run_frame(input bit started, input int mode);
    bit seen;
    int last_pd;
    last_pd = 0;
    if (!started) begin
      start = 1; tick(); start = 0;
    end
    for (int p = 0; p < N; p++) begin
      wait_load(seen);
      cmp("load_seen", seen, 1);
      if (!seen) return;
      got[p] = pix_data;
      tick();
      if (mode == 2 && p == 2) begin
        wr_en = 1; wr_addr = 3'd5; wr_data = 24'hABCDEF; tick(); wr_en = 0;
      end
      if (mode == 1 && p == 4) begin
        start = 1; tick(); start = 0;
      end
      repeat (p % 3) tick();
      pix_done = 1; last_pd = cyc; tick(); pix_done = 0;
    end
    if (mode == 1) begin
      repeat (10) tick();
      pix_done = 1; tick(); pix_done = 0;
      start = 1; tick(); start = 0;
    end
    for (int k = 0; k < LATCH + 200; k++) begin
      if (frame_done) break;
      tick();
    end
    cmp("done_seen", frame_done, 1);
    cmp("latch_gap", 32'(cyc - last_pd), 4001);
    cmp("busy_at_done", busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int pd, loads;
    // reset held with start asserted
    reset_n = 0; start = 1;
    repeat (4) tick();
    reset_n = 1; start = 0;
    repeat (3) tick();
    cmp("idle_busy", busy, 0);
    cmp("idle_load", pix_load, 0);

    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 24'(16 * (i + 1)); tick();
    end
    wr_en = 0;
    pix_done = 1; tick(); pix_done = 0;
    tick();

    run_frame(0, 0);
    for (int i = 0; i < N; i++) cmp("basic_pix", got[i], 32'(16 * (i + 1)));
    repeat (3) tick();

    run_frame(0, 1);
    for (int i = 0; i < N; i++) cmp("ignored_pix", got[i], 32'(16 * (i + 1)));
    repeat (3) tick();

    run_frame(0, 2);
    cmp("live_write", got[5], 24'hABCDEF);
    cmp("live_pix4", got[4], 24'h000050);
    cmp("live_pix6", got[6], 24'h000070);
    repeat (3) tick();

    // mid-frame reset during pixel 3
    start = 1; tick(); start = 0;
    for (int p = 0; p < 3; p++) begin
      wait_load(seen);
      tick();
      pix_done = 1; tick(); pix_done = 0;
    end
    wait_load(seen);
    cmp("pix3_data", pix_data, 24'h000040);
    tick();
    reset_n = 0; tick();
    cmp("midrst_busy", busy, 0);
    tick();
    reset_n = 1;
    repeat (20) tick();
    cmp("after_rst_busy", busy, 0);

    run_frame(0, 0);
    cmp("restart_pix0", got[0], 24'h000010);
    cmp("restart_pix5", got[5], 24'hABCDEF);

    // back-to-back: start in the frame_done cycle
    start = 1; tick(); start = 0;
    cmp("b2b_load", pix_load, 1);
    cmp("b2b_data", pix_data, 24'h000010);
    run_frame(1, 0);
    cmp("b2b_last", got[7], 24'h000080);

    // single-pixel instance, plus an out-of-range write
    s_wr_en = 1; s_wr_addr = 1'b0; s_wr_data = 24'h123456; tick();
    s_wr_addr = 1'b1; s_wr_data = 24'hFFFFFF; tick();
    s_wr_en = 0;
    s_start = 1; tick(); s_start = 0;
    cmp("one_load", s_pix_load, 1);
    cmp("one_data", s_pix_data, 24'h123456);
    cmp("one_busy", s_busy, 1);
    tick(); tick();
    s_pix_done = 1; pd = cyc; tick(); s_pix_done = 0;
    loads = 0;
    for (int k = 0; k < 100; k++) begin
      if (s_frame_done) break;
      if (s_pix_load) loads++;
      tick();
    end
    cmp("one_extra_loads", loads, 0);
    cmp("one_done", s_frame_done, 1);
    cmp("one_gap", 32'(cyc - pd), 51);
    cmp("one_data_hold", s_pix_data, 24'h123456);
    tick();
    cmp("one_done_pulse", s_frame_done, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
